// File: rtl/jtbubl_sndcmd_ctrl.sv
// Sound command scheduler: queues main-CPU commands and presents them one at a time to the sound Z80.
// Optional JTBUBL_SNDCMD_OVWR_EN: a write while full replaces the newest queued command instead of dropping it.
module jtbubl_sndcmd_ctrl #(
    parameter int AW      = 2,
    parameter int NMI_W   = 8,
    parameter int HOLDOFF = 16
) (
    input  logic          clk,
    input  logic          snd_rstn,
    input  logic          main_wr,
    input  logic [7:0]    main_din,
    output logic          main_full,
    output logic          main_ovf,
    input  logic          ovf_clr,
    input  logic          snd_rd,
    input  logic          nmi_en,
    output logic [7:0]    snd_latch,
    output logic          snd_flag,
    output logic          nmi_n,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;
    localparam int LW    = AW + 1;

    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [7:0]      r_latch, r_nmi_cnt, r_gap_cnt;
    logic            r_flag, r_nmi_n, r_nmi_done, r_ovf;
    logic            w_full, w_push, w_pop, w_ovf, w_rd_ack;

    assign w_full   = (r_level == LW'(DEPTH));
    assign w_push   = main_wr && !w_full;
    assign w_ovf    = main_wr && w_full;
    assign w_pop    = (r_state == IDLE) && (r_level != '0);
    assign w_rd_ack = (r_state == PRESENT) && snd_rd;

    always_ff @(posedge clk or negedge snd_rstn) begin
        if (!snd_rstn) r_state <= IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_pop)             w_next = PRESENT;
            PRESENT: if (snd_rd)            w_next = GAP;
            GAP:     if (r_gap_cnt == 8'd0) w_next = IDLE;
            default:                        w_next = IDLE;
        endcase
    end

`ifdef JTBUBL_SNDCMD_OVWR_EN
    logic [AW-1:0] w_wr_last;
    assign w_wr_last = r_wr_ptr - AW'(1);
`endif

    // Storage carries no reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= main_din;
`ifdef JTBUBL_SNDCMD_OVWR_EN
        else if (w_ovf)
            r_mem[w_wr_last] <= main_din;
`endif
    end

    always_ff @(posedge clk or negedge snd_rstn) begin
        if (!snd_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            // A fresh overflow takes priority over a clear in the same cycle.
            if (w_ovf)        r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge snd_rstn) begin
        if (!snd_rstn) begin
            r_latch   <= 8'h00;
            r_flag    <= 1'b0;
            r_gap_cnt <= 8'd0;
        end else begin
            if (w_pop) begin
                r_latch <= r_mem[r_rd_ptr];
                r_flag  <= 1'b1;
            end else if (w_rd_ack) begin
                r_flag  <= 1'b0;
            end
            if (w_rd_ack)
                r_gap_cnt <= 8'(HOLDOFF);
            else if (r_state == GAP && r_gap_cnt != 8'd0)
                r_gap_cnt <= r_gap_cnt - 8'd1;
        end
    end

    // One NMI pulse per command; nmi_en only gates the start, never cuts a running pulse.
    always_ff @(posedge clk or negedge snd_rstn) begin
        if (!snd_rstn) begin
            r_nmi_n    <= 1'b1;
            r_nmi_cnt  <= 8'd0;
            r_nmi_done <= 1'b0;
        end else if (w_pop) begin
            r_nmi_done <= nmi_en;
            if (nmi_en) begin
                r_nmi_n   <= 1'b0;
                r_nmi_cnt <= 8'(NMI_W);
            end
        end else if (w_rd_ack) begin
            r_nmi_n   <= 1'b1;
            r_nmi_cnt <= 8'd0;
        end else if (r_state == PRESENT && r_flag && nmi_en && !r_nmi_done) begin
            r_nmi_n    <= 1'b0;
            r_nmi_cnt  <= 8'(NMI_W);
            r_nmi_done <= 1'b1;
        end else if (!r_nmi_n) begin
            if (r_nmi_cnt == 8'd1) begin
                r_nmi_n   <= 1'b1;
                r_nmi_cnt <= 8'd0;
            end else begin
                r_nmi_cnt <= r_nmi_cnt - 8'd1;
            end
        end
    end

    assign main_full = w_full;
    assign main_ovf  = r_ovf;
    assign snd_latch = r_latch;
    assign snd_flag  = r_flag;
    assign nmi_n     = r_nmi_n;
    assign level     = r_level;

endmodule
